// File: rtl/coincidence_shift_register.sv
// Shift-register coincidence counter for neutron multiplicity assay: gated R+A and
// long-delayed A accumulation of detector events under a start/stop measurement sequencer.
module coincidence_shift_register #(
  parameter int unsigned PREDELAY   = 8,
  parameter int unsigned GATE       = 128,
  parameter int unsigned LONG_DELAY = 1024,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned WIN_W      = $clog2(GATE + 1)
) (
  input  logic              i_clk_1mhz,
  input  logic              i_reset_n,
  input  logic              i_pulse,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [TIME_W-1:0] i_meas_cycles,
  output logic [CNT_W-1:0]  o_total_count,
  output logic [CNT_W-1:0]  o_r_plus_a_count,
  output logic [CNT_W-1:0]  o_a_count,
  output logic [WIN_W-1:0]  o_window,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_valid,
  output logic              o_overflow
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam int unsigned SumW = ((CNT_W > WIN_W) ? CNT_W : WIN_W) + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e              state_q;
  logic                pulse_q;
  logic [PREDELAY-1:0]   pd_q;
  logic [GATE-1:0]       gt_q;
  logic [LONG_DELAY-1:0] lg_q;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [TIME_W-1:0]   timer_q;
  logic [CNT_W-1:0]    total_q, ra_q, a_q;
  logic                done_q, valid_q, ovf_q;

  logic ev, pd_out, gt_out, lg_out, ovf_hit;

  function automatic logic [SumW-1:0] wide_sum(logic [CNT_W-1:0] acc, logic [WIN_W-1:0] inc);
    return SumW'(acc) + SumW'(inc);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] acc, logic [WIN_W-1:0] inc);
    logic [SumW-1:0] sum;
    sum = wide_sum(acc, inc);
    return (sum > SumW'(CntMax)) ? CntMax : sum[CNT_W-1:0];
  endfunction

  function automatic logic sat_hit(logic [CNT_W-1:0] acc, logic [WIN_W-1:0] inc);
    return wide_sum(acc, inc) > SumW'(CntMax);
  endfunction

  assign ev     = i_pulse & ~pulse_q;
  assign pd_out = pd_q[PREDELAY-1];
  assign gt_out = gt_q[GATE-1];
  assign lg_out = lg_q[LONG_DELAY-1];

  // win_d is W at the current edge; both accumulators add it, o_window shows it one edge later
  always_comb begin
    win_d = win_q;
    unique case ({pd_out, gt_out})
      2'b10:   win_d = win_q + WIN_W'(1);
      2'b01:   win_d = win_q - WIN_W'(1);
      default: win_d = win_q;
    endcase
  end

  always_comb begin
    ovf_hit = 1'b0;
    if (ev && (sat_hit(total_q, WIN_W'(1)) || sat_hit(ra_q, win_d))) ovf_hit = 1'b1;
    if (lg_out && sat_hit(a_q, win_d)) ovf_hit = 1'b1;
  end

  always_ff @(posedge i_clk_1mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      pulse_q <= 1'b0;
      pd_q    <= '0;
      gt_q    <= '0;
      lg_q    <= '0;
      win_q   <= '0;
      timer_q <= '0;
      total_q <= '0;
      ra_q    <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // Delay lines and window run in every state so IDLE events still feed later runs
      pulse_q <= i_pulse;
      pd_q    <= (pd_q << 1) | PREDELAY'(ev);
      gt_q    <= (gt_q << 1) | GATE'(pd_out);
      lg_q    <= (lg_q << 1) | LONG_DELAY'(ev);
      win_q   <= win_d;
      done_q  <= 1'b0;
      if (i_start) begin
        state_q <= StRun;
        timer_q <= i_meas_cycles;
        total_q <= '0;
        ra_q    <= '0;
        a_q     <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state_q == StRun) begin
        if (ev) begin
          total_q <= sat_add(total_q, WIN_W'(1));
          ra_q    <= sat_add(ra_q, win_d);
        end
        if (lg_out) a_q <= sat_add(a_q, win_d);
        ovf_q <= ovf_q | ovf_hit;
        // A zero length never reaches 1, so such a run only ends on i_stop
        if (i_stop || (timer_q == TIME_W'(1))) begin
          state_q <= StIdle;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end else if (timer_q != '0) begin
          timer_q <= timer_q - TIME_W'(1);
        end
      end
    end
  end

  assign o_total_count    = total_q;
  assign o_r_plus_a_count = ra_q;
  assign o_a_count        = a_q;
  assign o_window         = win_q;
  assign o_busy           = (state_q == StRun);
  assign o_done           = done_q;
  assign o_valid          = valid_q;
  assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_coincidence_shift_register.sv
// Bench for coincidence_shift_register: directed and random stimulus against an event-list
// model that recomputes the window from event timestamps every cycle.
module tb_coincidence_shift_register;

  localparam int P  = 8;
  localparam int G  = 128;
  localparam int LD = 1024;
  localparam longint Max24 = (64'd1 << 24) - 1;
  localparam longint Max4  = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pulse = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] meas = '0;
  logic [23:0] tot, ra, a;
  logic [7:0]  win, win_s;
  logic        busy, done, valid, ovf;
  logic [3:0]  tot_s, ra_s, a_s;
  logic        busy_s, done_s, valid_s, ovf_s;

  coincidence_shift_register dut (
    .i_clk_1mhz(clk), .i_reset_n(rst_n), .i_pulse(pulse), .i_start(start), .i_stop(stop),
    .i_meas_cycles(meas), .o_total_count(tot), .o_r_plus_a_count(ra), .o_a_count(a),
    .o_window(win), .o_busy(busy), .o_done(done), .o_valid(valid), .o_overflow(ovf)
  );

  coincidence_shift_register #(.CNT_W(4)) dut_s (
    .i_clk_1mhz(clk), .i_reset_n(rst_n), .i_pulse(pulse), .i_start(start), .i_stop(stop),
    .i_meas_cycles(meas), .o_total_count(tot_s), .o_r_plus_a_count(ra_s), .o_a_count(a_s),
    .o_window(win_s), .o_busy(busy_s), .o_done(done_s), .o_valid(valid_s), .o_overflow(ovf_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: event timestamps plus run bookkeeping
  int     k;
  int     evq[$];
  bit     m_prev, m_busy, m_done, m_valid, m_ovf, m_ovf_s;
  longint m_tot, m_ra, m_a, m_tot_s, m_ra_s, m_a_s, m_meas, run_cnt;
  int     m_win;
  int     busy_seen, done_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    evq.delete();
    m_prev = 0; m_busy = 0; m_done = 0; m_valid = 0; m_ovf = 0; m_ovf_s = 0;
    m_tot = 0; m_ra = 0; m_a = 0; m_tot_s = 0; m_ra_s = 0; m_a_s = 0;
    m_meas = 0; run_cnt = 0; m_win = 0; k = 0;
  endtask

  task automatic acc(inout longint v, input longint inc, input longint mx, inout bit of);
    if (v + inc > mx) begin
      v  = mx;
      of = 1;
    end else begin
      v = v + inc;
    end
  endtask

  task automatic model_step(input bit p, input bit st, input bit sp, input longint ms);
    bit ev, atrig;
    int w, d;
    ev = p && !m_prev;
    m_prev = p;
    if (ev) evq.push_back(k);
    w = 0;
    atrig = 0;
    foreach (evq[i]) begin
      d = k - evq[i];
      if (d >= P && d < P + G) w++;
      if (d == LD) atrig = 1;
    end
    while (evq.size() > 0 && k - evq[0] >= LD) void'(evq.pop_front());
    m_done = 0;
    if (st) begin
      m_busy = 1; m_valid = 0; m_ovf = 0; m_ovf_s = 0;
      m_tot = 0; m_ra = 0; m_a = 0; m_tot_s = 0; m_ra_s = 0; m_a_s = 0;
      m_meas = ms; run_cnt = 0;
    end else if (m_busy) begin
      if (ev) begin
        acc(m_tot, 1, Max24, m_ovf);  acc(m_ra, w, Max24, m_ovf);
        acc(m_tot_s, 1, Max4, m_ovf_s); acc(m_ra_s, w, Max4, m_ovf_s);
      end
      if (atrig) begin
        acc(m_a, w, Max24, m_ovf);
        acc(m_a_s, w, Max4, m_ovf_s);
      end
      run_cnt++;
      if (sp || (m_meas != 0 && run_cnt == m_meas)) begin
        m_busy = 0; m_done = 1; m_valid = 1;
      end
    end
    m_win = w;
    k++;
  endtask

  task automatic check_all();
    chk("total", tot, m_tot);
    chk("r_plus_a", ra, m_ra);
    chk("a", a, m_a);
    chk("window", win, m_win);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("valid", valid, m_valid);
    chk("overflow", ovf, m_ovf);
    chk("total_w4", tot_s, m_tot_s);
    chk("r_plus_a_w4", ra_s, m_ra_s);
    chk("a_w4", a_s, m_a_s);
    chk("overflow_w4", ovf_s, m_ovf_s);
  endtask

  task automatic cyc(input bit p, input bit st, input bit sp, input int unsigned ms);
    pulse = p; start = st; stop = sp; meas = ms;
    @(posedge clk);
    model_step(p, st, sp, ms);
    #1;
    check_all();
    if (busy) busy_seen++;
    if (done) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      cyc(0, 0, 0, 0);
      i++;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int gaps[4];
    int exp_ra[4];
    bit p;
    gaps   = '{8, 7, 135, 136};
    exp_ra = '{1, 0, 1, 0};
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Gate edges: second event at predelay, just before it, at gate end, just past it
    for (int g = 0; g < 4; g++) begin
      idle(150);
      cyc(0, 1, 0, 200);
      idle(5);
      cyc(1, 0, 0, 0);
      idle(gaps[g] - 1);
      cyc(1, 0, 0, 0);
      wait_done("gate_done", 300);
      chk("gate_r_plus_a", ra, exp_ra[g]);
      chk("gate_total", tot, 2);
    end

    // Isolated event, then a 3-event burst, each in a 2000-cycle run
    idle(1100);
    cyc(0, 1, 0, 2000);
    idle(10);
    cyc(1, 0, 0, 0);
    wait_done("single_done", 2100);
    chk("single_total", tot, 1);
    chk("single_r_plus_a", ra, 0);
    chk("single_a", a, 0);
    idle(1100);
    cyc(0, 1, 0, 2000);
    for (int e = 0; e < 3; e++) begin
      cyc(1, 0, 0, 0);
      idle(9);
    end
    wait_done("burst_done", 2100);
    chk("burst_total", tot, 3);
    chk("burst_r_plus_a", ra, 3);

    // Fixed length run with a long pulse
    idle(20);
    busy_seen = 0;
    done_seen = 0;
    cyc(0, 1, 0, 100);
    for (int i = 0; i < 50; i++) cyc(1, 0, 0, 0);
    idle(70);
    chk("len_busy_cycles", busy_seen, 100);
    chk("len_done_pulses", done_seen, 1);
    chk("len_total", tot, 1);

    // Open-ended run ended by stop; then start+stop collision restarts
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 300; i++) cyc(($urandom_range(0, 3) == 0), 0, 0, 0);
    chk("open_busy", busy, 1'b1);
    cyc(0, 0, 1, 0);
    chk("stop_done", done, 1'b1);
    chk("stop_valid", valid, 1'b1);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(i[1], 0, 0, 0);
    cyc(0, 1, 1, 0);
    chk("collide_busy", busy, 1'b1);
    chk("collide_total", tot, 0);
    idle(5);
    cyc(0, 0, 1, 0);

    // Random runs, pulses, stops and restarts
    p = 0;
    for (int r = 0; r < 8; r++) begin
      cyc(0, 1, 0, $urandom_range(1, 300));
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 2) == 0) p = ~p;
        cyc(p, ($urandom_range(0, 299) == 0), ($urandom_range(0, 199) == 0),
            $urandom_range(0, 200));
      end
    end
    cyc(0, 0, 1, 0);

    // Saturation in the 4-bit instance
    idle(200);
    cyc(0, 1, 0, 0);
    for (int e = 0; e < 20; e++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    chk("sat_total_w4", tot_s, 15);
    chk("sat_overflow_w4", ovf_s, 1'b1);
    chk("sat_total_w24", tot, 20);
    cyc(0, 0, 1, 0);
    idle(10);
    chk("sat_sticky_w4", ovf_s, 1'b1);
    cyc(0, 1, 0, 0);
    chk("sat_cleared_w4", ovf_s, 1'b0);

    // Asynchronous reset in the middle of a run
    for (int e = 0; e < 10; e++) begin
      cyc(1, 0, 0, 0);
      idle(3);
    end
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #3 rst_n = 1'b1;
    done_seen = 0;
    idle(20);
    chk("post_reset_no_done", done_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
